modport_lane_bank: RTL and testbench

//  Bank of WIDTH independent 1-bit lanes; each lane is statically bound to one of two

---
 rtl/modport_lane_pkg.sv | 17 +
 rtl/modport_lane.sv | 52 +++++
 rtl/modport_lane_bank.sv | 66 ++++++
 tb/tb_modport_lane_bank.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/modport_lane_pkg.sv
// Shared types and helpers for the modport lane bank.
// Lane view encoding, the view function and the register reset value.
package modport_lane_pkg;

    typedef enum logic {
        MP_VIEW_A = 1'b0,
        MP_VIEW_B = 1'b1
    } mp_view_e;

    localparam logic MP_RST_VAL = 1'b0;

    // View A sees the inverted input, view B sees it unchanged.
    function automatic logic lane_view(mp_view_e sel, logic i);
        return (sel == MP_VIEW_B) ? i : ~i;
    endfunction

endpackage

// File: rtl/modport_lane.sv
// One registered lane: view, flip and field routing.
// A lanes drive v, B lanes drive o; the other field is held at 0.
module modport_lane
    import modport_lane_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  logic     i,
    input  mp_view_e view_sel,
    input  logic     flip,
    output logic     i_view,
    output logic     v,
    output logic     o
);

    logic iv_d, iv_q;
    logic v_d, v_q;
    logic o_d, o_q;
    logic drv;

    // Next state: view of the input, flipped, routed to one field.
    always_comb begin
        iv_d = lane_view(view_sel, i);
        drv  = iv_d ^ flip;
        v_d  = MP_RST_VAL;
        o_d  = MP_RST_VAL;
        if (view_sel == MP_VIEW_A) begin
            v_d = drv;
        end else begin
            o_d = drv;
        end
    end

    // Registers: reset wins, otherwise load only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            iv_q <= MP_RST_VAL;
            v_q  <= MP_RST_VAL;
            o_q  <= MP_RST_VAL;
        end else if (en) begin
            iv_q <= iv_d;
            v_q  <= v_d;
            o_q  <= o_d;
        end
    end

    assign i_view = iv_q;
    assign v      = v_q;
    assign o      = o_q;

endmodule

// File: rtl/modport_lane_bank.sv
// Bank of WIDTH registered lanes with concatenated and sliced drive.
// Optional per-update lane trace under MODPORT_LANE_TRACE_EN.
module modport_lane_bank
    import modport_lane_pkg::*;
#(
    parameter int               WIDTH    = 3,
    parameter logic [WIDTH-1:0] FLIP     = 3'b011,
    parameter logic [WIDTH-1:0] SEL      = 3'b000,
    parameter int               SLICE_HI = 2,
    parameter int               SLICE_LO = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [WIDTH-1:0]         i_in,
    output logic [WIDTH-1:0]         i_view,
    output logic [WIDTH-1:0]         v_out,
    output logic [WIDTH-1:0]         o_out,
    output logic [WIDTH-1:0]         drive_concat,
    output logic [SLICE_HI-SLICE_LO:0] slice_out
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "modport_lane_bank: WIDTH must be >= 1");
    end

    if (SLICE_LO < 0 || SLICE_HI < SLICE_LO || SLICE_HI > WIDTH - 1)
    begin : g_bad_slice
        $fatal(1, "modport_lane_bank: illegal SLICE range");
    end

    for (genvar k = WIDTH - 1; k >= 0; k--) begin : g_lane
        modport_lane u_lane (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .i        (i_in[k]),
            .view_sel (mp_view_e'(SEL[k])),
            .flip     (FLIP[k]),
            .i_view   (i_view[k]),
            .v        (v_out[k]),
            .o        (o_out[k])
        );
    end

    assign drive_concat = (v_out & ~SEL) | (o_out & SEL);
    assign slice_out    = drive_concat[SLICE_HI:SLICE_LO];

`ifdef MODPORT_LANE_TRACE_EN
    initial begin
        $display("modport_lane_bank WIDTH=%0d SEL=%b FLIP=%b",
                 WIDTH, SEL, FLIP);
    end

    // Trace the settled lane registers after every update edge.
    always @(posedge clk) begin
        if (!rst && en) begin
            for (int k = WIDTH - 1; k >= 0; k--) begin
                $strobe("L%0d i = %b, v = %b, o = %b",
                        k, i_view[k], v_out[k], o_out[k]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_modport_lane_bank.sv
// Self-checking bench for modport_lane_bank.
// Five parameterisations share clk/rst/en and are tracked by a vector model.
module tb_modport_lane_bank;

    localparam int NI = 5;
    localparam logic [7:0] SELS  [NI] = '{8'h00, 8'h07, 8'h02, 8'h01, 8'hA5};
    localparam logic [7:0] FLIPS [NI] = '{8'h03, 8'h01, 8'h00, 8'h00, 8'h3C};
    localparam logic [7:0] MASKS [NI] = '{8'h07, 8'h07, 8'h07, 8'h01, 8'hFF};
    localparam int         HIS   [NI] = '{2, 2, 2, 0, 6};
    localparam int         LOS   [NI] = '{0, 0, 1, 0, 2};

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] i3;
    logic [0:0] i1;
    logic [7:0] i8;

    int checks   = 0;
    int failures = 0;

    logic [2:0] a_iv, a_v, a_o, a_dc, a_sl;
    logic [2:0] b_iv, b_v, b_o, b_dc, b_sl;
    logic [2:0] c_iv, c_v, c_o, c_dc;
    logic [1:0] c_sl;
    logic [0:0] d_iv, d_v, d_o, d_dc, d_sl;
    logic [7:0] e_iv, e_v, e_o, e_dc;
    logic [4:0] e_sl;

    logic [7:0] act_iv [NI];
    logic [7:0] act_v  [NI];
    logic [7:0] act_o  [NI];
    logic [7:0] act_dc [NI];
    logic [7:0] act_sl [NI];

    logic [7:0] exp_iv [NI];
    logic [7:0] exp_v  [NI];
    logic [7:0] exp_o  [NI];

    always #5 clk = ~clk;

    modport_lane_bank u_a (
        .clk(clk), .rst(rst), .en(en), .i_in(i3),
        .i_view(a_iv), .v_out(a_v), .o_out(a_o),
        .drive_concat(a_dc), .slice_out(a_sl)
    );

    modport_lane_bank #(.WIDTH(3), .FLIP(3'b001), .SEL(3'b111),
                        .SLICE_HI(2), .SLICE_LO(0)) u_b (
        .clk(clk), .rst(rst), .en(en), .i_in(i3),
        .i_view(b_iv), .v_out(b_v), .o_out(b_o),
        .drive_concat(b_dc), .slice_out(b_sl)
    );

    modport_lane_bank #(.WIDTH(3), .FLIP(3'b000), .SEL(3'b010),
                        .SLICE_HI(2), .SLICE_LO(1)) u_c (
        .clk(clk), .rst(rst), .en(en), .i_in(i3),
        .i_view(c_iv), .v_out(c_v), .o_out(c_o),
        .drive_concat(c_dc), .slice_out(c_sl)
    );

    modport_lane_bank #(.WIDTH(1), .FLIP(1'b0), .SEL(1'b1),
                        .SLICE_HI(0), .SLICE_LO(0)) u_d (
        .clk(clk), .rst(rst), .en(en), .i_in(i1),
        .i_view(d_iv), .v_out(d_v), .o_out(d_o),
        .drive_concat(d_dc), .slice_out(d_sl)
    );

    modport_lane_bank #(.WIDTH(8), .FLIP(8'h3C), .SEL(8'hA5),
                        .SLICE_HI(6), .SLICE_LO(2)) u_e (
        .clk(clk), .rst(rst), .en(en), .i_in(i8),
        .i_view(e_iv), .v_out(e_v), .o_out(e_o),
        .drive_concat(e_dc), .slice_out(e_sl)
    );

    always_comb begin
        act_iv[0] = {5'b0, a_iv}; act_v[0] = {5'b0, a_v};
        act_o[0]  = {5'b0, a_o};  act_dc[0] = {5'b0, a_dc};
        act_sl[0] = {5'b0, a_sl};
        act_iv[1] = {5'b0, b_iv}; act_v[1] = {5'b0, b_v};
        act_o[1]  = {5'b0, b_o};  act_dc[1] = {5'b0, b_dc};
        act_sl[1] = {5'b0, b_sl};
        act_iv[2] = {5'b0, c_iv}; act_v[2] = {5'b0, c_v};
        act_o[2]  = {5'b0, c_o};  act_dc[2] = {5'b0, c_dc};
        act_sl[2] = {6'b0, c_sl};
        act_iv[3] = {7'b0, d_iv}; act_v[3] = {7'b0, d_v};
        act_o[3]  = {7'b0, d_o};  act_dc[3] = {7'b0, d_dc};
        act_sl[3] = {7'b0, d_sl};
        act_iv[4] = e_iv; act_v[4] = e_v;
        act_o[4]  = e_o;  act_dc[4] = e_dc;
        act_sl[4] = {3'b0, e_sl};
    end

    // Apply one rising edge to the model using the inputs present
    // before the edge, then settle 1 time unit past the edge.
    task automatic step();
        logic [7:0] inp [NI];
        logic       r;
        logic       e;
        logic [7:0] drv;
        r = rst;
        e = en;
        for (int n = 0; n < 3; n++) inp[n] = {5'b0, i3};
        inp[3] = {7'b0, i1};
        inp[4] = i8;
        @(posedge clk);
        #1;
        for (int n = 0; n < NI; n++) begin
            if (r) begin
                exp_iv[n] = 8'h00;
                exp_v[n]  = 8'h00;
                exp_o[n]  = 8'h00;
            end else if (e) begin
                exp_iv[n] = (inp[n] ^ ~SELS[n]) & MASKS[n];
                drv       = exp_iv[n] ^ FLIPS[n];
                exp_v[n]  = drv & ~SELS[n] & MASKS[n];
                exp_o[n]  = drv & SELS[n] & MASKS[n];
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1;
        i3 = 3'b111; i1 = 1'b1; i8 = 8'hFF;
        for (int c = 0; c < 2; c++) begin
            step();
            for (int n = 0; n < NI; n++) begin
                checks++;
                if ({act_iv[n], act_v[n], act_o[n], act_dc[n], act_sl[n]}
                    !== 40'h0) begin
                    failures++;
                    $display("FAIL reset inst%0d cyc%0d iv=%h v=%h o=%h dc=%h sl=%h want 0",
                             n, c, act_iv[n], act_v[n], act_o[n],
                             act_dc[n], act_sl[n]);
                end
            end
        end
        rst = 1'b0; en = 1'b0;
        #3;
        for (int n = 0; n < NI; n++) begin
            checks++;
            if ({act_iv[n], act_v[n], act_o[n], act_dc[n], act_sl[n]}
                !== 40'h0) begin
                failures++;
                $display("FAIL reset_after inst%0d v=%h dc=%h want 0",
                         n, act_v[n], act_dc[n]);
            end
        end
    endtask

    task automatic test_directed();
        en = 1'b1; i3 = 3'b000;
        step();
        checks++;
        if ({a_iv, a_v, a_o, a_dc} !== {3'b111, 3'b100, 3'b000, 3'b100}) begin
            failures++;
            $display("FAIL dir_a iv=%b v=%b o=%b dc=%b want 111 100 000 100",
                     a_iv, a_v, a_o, a_dc);
        end
        checks++;
        if ({c_iv, c_v, c_o, c_dc, c_sl} !==
            {3'b101, 3'b101, 3'b000, 3'b101, 2'b10}) begin
            failures++;
            $display("FAIL dir_c iv=%b v=%b o=%b dc=%b sl=%b want 101 101 000 101 10",
                     c_iv, c_v, c_o, c_dc, c_sl);
        end
        i3 = 3'b101;
        step();
        checks++;
        if ({b_iv, b_o, b_v, b_dc} !== {3'b101, 3'b100, 3'b000, 3'b100}) begin
            failures++;
            $display("FAIL dir_b iv=%b o=%b v=%b dc=%b want 101 100 000 100",
                     b_iv, b_o, b_v, b_dc);
        end
    endtask

    task automatic test_toggle_hold();
        logic [2:0] seq  [4] = '{3'b000, 3'b111, 3'b000, 3'b111};
        logic [2:0] want [4] = '{3'b100, 3'b011, 3'b100, 3'b011};
        logic [2:0] prev;
        en = 1'b1;
        for (int s = 0; s < 4; s++) begin
            prev = a_v;
            i3 = seq[s];
            #1;
            checks++;
            if (a_v !== prev) begin
                failures++;
                $display("FAIL toggle_early s%0d v=%b want %b", s, a_v, prev);
            end
            step();
            checks++;
            if (a_v !== want[s]) begin
                failures++;
                $display("FAIL toggle s%0d v=%b want %b", s, a_v, want[s]);
            end
        end
        en = 1'b0; i3 = 3'b000;
        for (int s = 0; s < 2; s++) begin
            step();
            checks++;
            if (a_v !== 3'b011) begin
                failures++;
                $display("FAIL hold s%0d v=%b want 011", s, a_v);
            end
        end
        rst = 1'b1; en = 1'b1;
        step();
        checks++;
        if (a_v !== 3'b000) begin
            failures++;
            $display("FAIL mid_reset v=%b want 000", a_v);
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] dc;
        for (int c = 0; c < 300; c++) begin
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 29) == 0);
            i3  = 3'($urandom);
            i1  = 1'($urandom);
            i8  = 8'($urandom);
            step();
            for (int n = 0; n < NI; n++) begin
                dc = exp_v[n] | exp_o[n];
                checks++;
                if (act_iv[n] !== exp_iv[n] || act_v[n] !== exp_v[n] ||
                    act_o[n] !== exp_o[n] || act_dc[n] !== dc ||
                    act_sl[n] !== 8'((dc >> LOS[n]) &
                                     ((8'd1 << (HIS[n] - LOS[n] + 1)) - 8'd1))) begin
                    failures++;
                    $display("FAIL rand c%0d inst%0d iv=%h/%h v=%h/%h o=%h/%h dc=%h/%h sl=%h",
                             c, n, act_iv[n], exp_iv[n], act_v[n], exp_v[n],
                             act_o[n], exp_o[n], act_dc[n], dc, act_sl[n]);
                end
                checks++;
                if (((act_v[n] & SELS[n]) | (act_o[n] & ~SELS[n])) !== 8'h00) begin
                    failures++;
                    $display("FAIL undriven c%0d inst%0d v=%h o=%h want 0 off-field",
                             c, n, act_v[n], act_o[n]);
                end
            end
        end
    endtask

    initial begin
        for (int n = 0; n < NI; n++) begin
            exp_iv[n] = 8'h00;
            exp_v[n]  = 8'h00;
            exp_o[n]  = 8'h00;
        end
        rst = 1'b1; en = 1'b0;
        i3 = 3'b000; i1 = 1'b0; i8 = 8'h00;
        #1;
        test_reset();
        test_directed();
        test_toggle_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
